// File: rtl/scratch_mem_pkg.sv
// Shared types and default geometry for the scratch memory bridge and its response FIFO.
package scratch_mem_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/scratch_resp_fifo.sv
// Circular response FIFO: up to two pushes per cycle (slot 0 is older than slot 1), one pop.
module scratch_resp_fifo
  import scratch_mem_pkg::*;
#(
  parameter int unsigned ENTRIES = 3,
  localparam int unsigned PTR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int unsigned CNT_W  = $clog2(ENTRIES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push0,
  input  resp_t            i_data0,
  input  logic             i_push1,
  input  resp_t            i_data1,
  input  logic             i_pop,
  output resp_t            o_data,
  output logic [CNT_W-1:0] o_count
);

  resp_t            r_mem [ENTRIES];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_wr_nxt2;
  logic [PTR_W-1:0] w_slot1;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_wr_nxt  = f_next(r_wr_ptr);
    w_wr_nxt2 = f_next(w_wr_nxt);
    w_slot1   = i_push0 ? w_wr_nxt : r_wr_ptr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push0) r_mem[r_wr_ptr] <= i_data0;
      if (i_push1) r_mem[w_slot1]  <= i_data1;
      if (i_push0 && i_push1)      r_wr_ptr <= w_wr_nxt2;
      else if (i_push0 || i_push1) r_wr_ptr <= w_wr_nxt;
      if (i_pop) r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/scratch_mem_bridge.sv
// Valid/ready front end for the 1024x32 scratch macro: zero-fill after reset, then
// in-order request/response traffic with buffered read data.
module scratch_mem_bridge
  import scratch_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = scratch_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W         = scratch_mem_pkg::DATA_W,
  parameter int unsigned RESP_DEPTH     = 3,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned MASK_W        = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_mask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              mem_W0_en,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic [DATA_W-1:0] mem_R0_data
);

  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_inflight;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_req_fire;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_pop;
  resp_t             w_cap_resp;
  resp_t             w_wr_resp;
  resp_t             w_fifo_out;

  // Every owed response (queued or in flight) holds a slot; a new request may take the
  // last free one, so a capture and a write landing together can never overflow.
  assign req_ready  = !reset && (r_state == RUN) &&
                      ((32'(w_fifo_count) + 32'(r_inflight)) < RESP_DEPTH);
  assign w_req_fire = req_valid && req_ready;
  assign w_wr_fire  = w_req_fire && req_write;
  assign w_rd_fire  = w_req_fire && !req_write;

  assign resp_valid = !reset && (w_fifo_count != '0);
  assign w_pop      = resp_valid && resp_ready;
  assign resp_write = w_fifo_out.write;
  assign resp_rdata = w_fifo_out.rdata;
  assign init_done  = reset ? !CLEAR_ON_RESET : (r_state == RUN);

  always_comb begin
    w_state_nxt = r_state;
    mem_W0_en   = 1'b0;
    mem_W0_addr = req_addr;
    mem_W0_data = req_wdata;
    mem_W0_mask = req_mask;
    mem_R0_en   = 1'b0;
    mem_R0_addr = req_addr;
    if (!reset) begin
      unique case (r_state)
        CLEAR: begin
          mem_W0_en   = 1'b1;
          mem_W0_addr = r_clr_cnt;
          mem_W0_data = '0;
          mem_W0_mask = '1;
          if (r_clr_cnt == '1) w_state_nxt = RUN;
        end
        RUN: begin
          mem_W0_en = w_wr_fire;
          mem_R0_en = w_rd_fire;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET) r_state <= CLEAR;
      else                r_state <= RUN;
      r_clr_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_inflight <= w_rd_fire;
    end
  end

  // The macro output tracks live RAM contents, so the capture must be pushed this cycle.
  assign w_cap_resp = '{write: 1'b0, rdata: mem_R0_data};
  assign w_wr_resp  = '{write: 1'b1, rdata: '0};

  scratch_resp_fifo #(
    .ENTRIES(RESP_DEPTH)
  ) u_resp_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push0 (r_inflight),
    .i_data0 (w_cap_resp),
    .i_push1 (w_wr_fire),
    .i_data1 (w_wr_resp),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_count (w_fifo_count)
  );

endmodule
